// File: rtl/nios_pio_in_edge.sv
// nios_pio_in_edge: Avalon-MM PIO input port with synchroniser, edge capture and level interrupt.
// Latency: in_port change reaches edgecapture after SYNC_STAGES+2 clk edges; readdata follows address by 1 cycle.
// Backpressure: none; the slave accepts every write and never inserts wait states, and reads have no side effects.
module nios_pio_in_edge #(
  parameter int WIDTH       = 10,  // input port width, 1..32
  parameter int SYNC_STAGES = 2,   // synchroniser depth, 2..4
  parameter int EDGE_TYPE   = 0,   // 0 rising, 1 falling, 2 any
  parameter int BIT_CLEAR   = 1    // 1 per-bit write-one-to-clear, 0 any write clears all
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Detection stays off until the synchroniser and prev_q both hold real input
  // levels, so levels present when reset drops are not mistaken for edges.
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  // Synchroniser: meta_q holds the leading stages, sync_q is the final stage.
  logic [WIDTH-1:0] meta_q [SYNC_STAGES-1];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  logic [2:0]       prime_q, prime_d;
  logic             det_en;

  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_q, edge_d;

  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_mask;

  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic             wr_mask;
  logic             wr_edge;

  // Upper writedata bits only matter when WIDTH is 32; fold them in here so
  // narrow configurations do not leave dangling inputs.
  logic             unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  // ---------------------------------------------------------------------------
  // Bus write decode: chipselect qualifies writes only.
  // ---------------------------------------------------------------------------
  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en & (address == ADDR_MASK);
  assign wr_edge = wr_en & (address == ADDR_EDGE);

  // ---------------------------------------------------------------------------
  // Edge polarity selection.
  // ---------------------------------------------------------------------------
  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = sync_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~sync_q & prev_q;
    end else begin : g_any
      assign edge_raw = sync_q ^ prev_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Clear mask for edgecapture writes.
  // ---------------------------------------------------------------------------
  generate
    if (BIT_CLEAR != 0) begin : g_bitclr
      assign clr_mask = wr_edge ? writedata[WIDTH-1:0] : '0;
    end else begin : g_allclr
      assign clr_mask = wr_edge ? {WIDTH{1'b1}} : '0;
    end
  endgenerate

  // Prime counter saturates at PRIME_MAX; detection enabled once it gets there.
  always_comb begin
    prime_d = prime_q;
    if (prime_q != PRIME_MAX) begin
      prime_d = prime_q + 3'd1;
    end
  end

  assign det_en = (prime_q == PRIME_MAX);

  // Registered edge vector, masked off while priming.
  always_comb begin
    edge_d = '0;
    if (det_en) begin
      edge_d = edge_raw;
    end
  end

  // Mask and capture next state; a new edge beats a same-cycle clear.
  always_comb begin
    irqmask_d = irqmask_q;
    if (wr_mask) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr_mask) | edge_q;
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d = 32'(sync_q);
      ADDR_RSVD: readdata_d = '0;
      ADDR_MASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGE: readdata_d = 32'(edgecap_q);
      default:   readdata_d = '0;
    endcase
  end

  // Input synchroniser chain and one-cycle delay for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES - 1; i++) begin
        meta_q[i] <= '0;
      end
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        meta_q[i] <= meta_q[i-1];
      end
      sync_q <= meta_q[SYNC_STAGES-2];
      prev_q <= sync_q;
    end
  end

  // Prime counter and registered edge vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= '0;
      edge_q  <= '0;
    end else begin
      prime_q <= prime_d;
      edge_q  <= edge_d;
    end
  end

  // Software-visible registers and the registered read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: doc/nios_pio_in_edge.md
NIOS_PIO_IN_EDGE -- requirements
Module: nios_pio_in_edge

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the input port width (legal 1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal 2..4).
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, selecting the capture edge: 0 rising, 1 falling, 2 any.
REQ-004 The block SHALL have parameter BIT_CLEAR, default 1: 1 means per-bit write-one-to-clear of edgecapture, 0 means any write clears all bits.
REQ-005 Port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port address, input, 2 bits: Avalon-MM register select.
REQ-008 Port chipselect, input, 1 bit: slave select; qualifies writes only.
REQ-009 Port write_n, input, 1 bit: active-low write strobe.
REQ-010 Port writedata, input, 32 bits: write data.
REQ-011 Port in_port, input, WIDTH bits: asynchronous external inputs (switches).
REQ-012 Port readdata, output, 32 bits: registered read data.
REQ-013 Port irq, output, 1 bit: level interrupt request.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-015 A delay register prev_q SHALL hold sync_q from the previous cycle.
REQ-016 The detected-edge vector SHALL be: EDGE_TYPE 0: sync_q & ~prev_q; EDGE_TYPE 1: ~sync_q & prev_q; EDGE_TYPE 2: sync_q ^ prev_q.
REQ-017 After reset deassertion, a prime counter SHALL suppress edge detection for SYNC_STAGES+1 cycles; detection is enabled from cycle SYNC_STAGES+2 onward, so static input levels present at reset do not register as edges.
REQ-018 Register map: 0 = data (RO, sync_q); 1 = reserved (reads 0, writes ignored); 2 = irqmask (RW, WIDTH bits); 3 = edgecapture (RO with clear-on-write).
REQ-019 A write SHALL occur in a cycle with chipselect=1 and write_n=0; irqmask captures writedata[WIDTH-1:0] at address 2.
REQ-020 edgecapture bit i SHALL set in the cycle after a detected edge on bit i and hold until cleared.
REQ-021 A write to address 3 SHALL clear edgecapture bits where writedata=1 (BIT_CLEAR=1), or all bits (BIT_CLEAR=0).
REQ-022 If a clear and a new edge on the same bit occur in the same cycle, the bit SHALL be set (set wins).
REQ-023 readdata SHALL be updated every cycle from the address-selected register, zero-extended to 32 bits, giving a read latency of 1 cycle; reads SHALL have no side effects.
REQ-024 irq SHALL equal OR-reduce(edgecapture & irqmask), derived combinationally from registers only.
REQ-025 Total latency from an in_port transition to edgecapture set SHALL be SYNC_STAGES+2 clk edges.
REQ-026 Bits 31..WIDTH of every readable register SHALL read 0.

Reset
REQ-027 While reset=1: sync chain, prev_q, irqmask, edgecapture, and readdata SHALL be 0; irq SHALL be 0; the prime counter SHALL be 0.
REQ-028 Reset assertion mid-operation SHALL clear all state immediately, without waiting for clk; a write coincident with reset SHALL be discarded.

Verification
REQ-029 Sequence: WIDTH=10, in_port=10'h2A5 held; wait 5 cycles; read address 0 -> readdata=32'h000002A5 one cycle after address is applied.
REQ-030 Sequence: reset released with in_port=10'h3FF -> edgecapture stays 0 and irq stays 0 (priming check).
REQ-031 Sequence: irqmask=10'h001; in_port bit0 0->1 -> edgecapture=10'h001 after 4 cycles; irq=1; write 32'h1 to address 3 -> edgecapture=0, irq=0.
REQ-032 Sequence: irqmask=0; rising edge on bit3 -> edgecapture=10'h008 and irq=0; write irqmask=10'h008 -> irq=1 the next cycle.
REQ-033 Sequence: bit5 edge lands in the same cycle as a write of 32'h20 to address 3 -> bit5 remains set (set wins).
REQ-034 Sequence: EDGE_TYPE=2 with a 1->0->1 pulse on bit9 cleared between edges -> each edge sets bit9 (10'h200); BIT_CLEAR=0 with a write of 0 to address 3 clears all bits.
